// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port RAM arbiter shared by fetch (IF) and memory (MEM) stages
// MEM has fixed priority; every access is a held request closed by a one-cycle ram_ack or a timeout.
module unified_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_valid,
   output logic              mem_stall,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_ack,
   output logic              timeout_err
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                drop_q, drop_d;
   logic                ram_req_q, ram_req_d;
   logic                ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic                if_valid_q, if_valid_d;
   logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
   logic                mem_valid_q, mem_valid_d;
   logic                timeout_err_q, timeout_err_d;

   logic                mem_pend, if_pend, if_keep;

   // A request whose completion pulse is showing this cycle is finished, not pending.
   assign mem_pend = mem_req & ~mem_valid_q;
   assign if_pend  = if_req & ~if_valid_q;
   assign if_keep  = ~drop_q & ~if_flush;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      drop_d        = drop_q;
      ram_req_d     = ram_req_q;
      ram_we_d      = ram_we_q;
      ram_addr_d    = ram_addr_q;
      ram_wdata_d   = ram_wdata_q;
      if_rdata_d    = if_rdata_q;
      if_valid_d    = 1'b0;
      mem_rdata_d   = mem_rdata_q;
      mem_valid_d   = 1'b0;
      timeout_err_d = timeout_err_q;
      case (state_q)
         IDLE: begin
            if (mem_pend) begin
               ram_addr_d  = mem_addr;
               ram_we_d    = mem_we;
               ram_wdata_d = mem_wdata;
               ram_req_d   = 1'b1;
               cnt_d       = 8'd0;
               state_d     = BUSY_MEM;
            end else if (if_pend && !if_flush) begin
               ram_addr_d = if_addr;
               ram_we_d   = 1'b0;
               ram_req_d  = 1'b1;
               cnt_d      = 8'd0;
               drop_d     = 1'b0;
               state_d    = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_MEM: begin
            if (state_q == BUSY_IF && if_flush) drop_d = 1'b1;
            if (ram_ack || cnt_q == CNT_LAST) begin
               ram_req_d = 1'b0;
               ram_we_d  = 1'b0;
               cnt_d     = 8'd0;
               state_d   = IDLE;
               if (!ram_ack) timeout_err_d = 1'b1;
               // A timed-out access still completes, with zero data, so the owner never hangs.
               if (state_q == BUSY_MEM) begin
                  mem_valid_d = 1'b1;
                  if (!ram_ack)       mem_rdata_d = '0;
                  else if (!ram_we_q) mem_rdata_d = ram_rdata;
               end else if (if_keep) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = ram_ack ? ram_rdata : '0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         drop_q        <= 1'b0;
         ram_req_q     <= 1'b0;
         ram_we_q      <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         if_rdata_q    <= '0;
         if_valid_q    <= 1'b0;
         mem_rdata_q   <= '0;
         mem_valid_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         drop_q        <= drop_d;
         ram_req_q     <= ram_req_d;
         ram_we_q      <= ram_we_d;
         ram_addr_q    <= ram_addr_d;
         ram_wdata_q   <= ram_wdata_d;
         if_rdata_q    <= if_rdata_d;
         if_valid_q    <= if_valid_d;
         mem_rdata_q   <= mem_rdata_d;
         mem_valid_q   <= mem_valid_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign ram_req     = ram_req_q;
   assign ram_we      = ram_we_q;
   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
   assign if_rdata    = if_rdata_q;
   assign if_valid    = if_valid_q;
   assign mem_rdata   = mem_rdata_q;
   assign mem_valid   = mem_valid_q;
   assign timeout_err = timeout_err_q;
   assign mem_stall   = mem_req & ~mem_valid_q;
   assign if_stall    = (if_req & ~if_valid_q) | mem_stall;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
// Requesters push expected completions; a monitor pops them on each valid pulse.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, if_flush, mem_req, mem_we;
   logic [31:0] if_addr, mem_addr, mem_wdata;
   logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
   logic        if_valid, if_stall, mem_valid, mem_stall;
   logic        ram_req, ram_we, ram_ack, timeout_err;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_stall(mem_stall),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .ram_ack(ram_ack), .timeout_err(timeout_err)
   );

   int          chk_cnt = 0;
   int          pass_cnt = 0;
   logic [31:0] exp_if_q[$];
   logic [31:0] exp_mem_q[$];
   logic [31:0] ref_mem[logic [31:0]];
   logic [31:0] ram_mem[logic [31:0]];
   logic [31:0] model_if_rdata = '0;
   logic [31:0] model_mem_rdata = '0;
   int          fixed_lat = -1;
   bit          ack_en = 1'b1;
   bit          inject_ack = 1'b0;
   int          last_req_cycles = 0;
   logic        cap_we;
   logic [31:0] cap_addr, cap_wd;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hA5C30F1E;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      ref_mem[a] = v;
      ram_mem[a] = v;
   endtask

   // RAM responder: acks after fixed_lat (or random 0..3) wait cycles, checks the request stays put.
   initial begin : ram_model
      bit in_txn;
      int left;
      int req_cycles;
      in_txn = 1'b0;
      left = 0;
      req_cycles = 0;
      ram_ack = 1'b0;
      ram_rdata = '0;
      forever begin
         @(negedge clk);
         ram_ack = 1'b0;
         ram_rdata = $urandom;
         if (inject_ack) begin
            ram_ack = 1'b1;
            inject_ack = 1'b0;
         end else if (!reset || !ram_req) begin
            in_txn = 1'b0;
         end else begin
            if (!in_txn) begin
               in_txn = 1'b1;
               req_cycles = 0;
               left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
               cap_addr = ram_addr;
               cap_we = ram_we;
               cap_wd = ram_wdata;
            end else begin
               check("ram_addr_hold", ram_addr, cap_addr);
               check("ram_we_hold", 32'(ram_we), 32'(cap_we));
               check("ram_wdata_hold", ram_wdata, cap_wd);
            end
            req_cycles++;
            last_req_cycles = req_cycles;
            if (ack_en && left == 0) begin
               ram_ack = 1'b1;
               in_txn = 1'b0;
               if (cap_we) ram_mem[cap_addr] = cap_wd;
               else ram_rdata = ram_mem.exists(cap_addr) ? ram_mem[cap_addr] : init_val(cap_addr);
            end else if (left > 0) begin
               left--;
            end
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (if_valid) begin
            if (exp_if_q.size() == 0) check("if_valid_unexpected", 32'd1, 32'd0);
            else check("if_rdata", if_rdata, exp_if_q.pop_front());
         end
         if (mem_valid) begin
            if (exp_mem_q.size() == 0) check("mem_valid_unexpected", 32'd1, 32'd0);
            else check("mem_rdata", mem_rdata, exp_mem_q.pop_front());
         end
      end
   end

   task automatic do_mem(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input bit exp_to, output int lat);
      bit done;
      @(negedge clk);
      mem_req = 1'b1;
      mem_we = we;
      mem_addr = addr;
      mem_wdata = wd;
      if (exp_to) model_mem_rdata = '0;
      else if (we) ref_mem[addr] = wd;
      else model_mem_rdata = ref_read(addr);
      exp_mem_q.push_back(model_mem_rdata);
      lat = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         lat++;
         if (mem_valid) done = 1'b1;
         else if (lat >= 100) begin
            check("mem_valid_bound", 32'd0, 32'd1);
            done = 1'b1;
         end else check("mem_stall_wait", 32'(mem_stall), 32'd1);
      end
      mem_req = 1'b0;
   endtask

   task automatic do_if(input logic [31:0] addr, output int lat, output int stall_n);
      bit done;
      @(negedge clk);
      if_req = 1'b1;
      if_addr = addr;
      model_if_rdata = ref_read(addr);
      exp_if_q.push_back(model_if_rdata);
      lat = 0;
      stall_n = 0;
      done = 1'b0;
      #1;
      if (if_stall) stall_n++;
      while (!done) begin
         @(negedge clk);
         lat++;
         if (if_valid) done = 1'b1;
         else if (lat >= 100) begin
            check("if_valid_bound", 32'd0, 32'd1);
            done = 1'b1;
         end else begin
            check("if_stall_wait", 32'(if_stall), 32'd1);
            if (if_stall) stall_n++;
         end
      end
      if_req = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      int lat_a, lat_b, sn, seen;
      reset = 1'b0;
      if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
      repeat (2) @(negedge clk);
      check("rst_ctrl", 32'({ram_req, ram_we, if_valid, mem_valid, timeout_err}), 32'd0);
      check("rst_ram_addr", ram_addr, 32'd0);
      check("rst_if_rdata", if_rdata, 32'd0);
      check("rst_mem_rdata", mem_rdata, 32'd0);
      reset = 1'b1;

      // zero-wait fetch
      preload(32'h10, 32'h8C220004);
      fixed_lat = 0;
      do_if(32'h10, lat_a, sn);
      check("if_zero_wait_lat", 32'(lat_a), 32'd2);
      check("if_zero_wait_stall", 32'(sn), 32'd2);
      check("if_zero_wait_req_cycles", 32'(last_req_cycles), 32'd1);
      #1 check("if_stall_after_valid", 32'(if_stall), 32'd0);

      // simultaneous IF and MEM: MEM first, IF after one bubble
      preload(32'h40, 32'hDEAD0001);
      preload(32'h20, 32'h20010005);
      fork
         do_mem(1'b0, 32'h40, 32'h0, 1'b0, lat_a);
         do_if(32'h20, lat_b, sn);
      join
      check("prio_mem_lat", 32'(lat_a), 32'd2);
      check("prio_if_lat", 32'(lat_b), 32'd4);

      // store with 3 wait cycles
      fixed_lat = 3;
      do_mem(1'b1, 32'h44, 32'h12345678, 1'b0, lat_a);
      check("store_lat", 32'(lat_a), 32'd5);
      check("store_req_cycles", 32'(last_req_cycles), 32'd4);
      check("store_we", 32'(cap_we), 32'd1);
      check("store_wdata", cap_wd, 32'h12345678);

      // flush one cycle before ack
      @(negedge clk);
      if_req = 1'b1;
      if_addr = 32'h24;
      repeat (3) @(negedge clk);
      if_flush = 1'b1;
      if_req = 1'b0;
      @(negedge clk);
      if_flush = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (if_valid) seen++;
      end
      check("flush_no_valid", 32'(seen), 32'd0);
      check("flush_if_rdata_kept", if_rdata, model_if_rdata);
      check("flush_ram_idle", 32'(ram_req), 32'd0);
      do_if(32'h28, lat_a, sn);
      check("post_flush_lat", 32'(lat_a), 32'd5);

      // randomized mixed traffic
      fixed_lat = -1;
      fork
         begin
            repeat (30) begin
               logic we;
               repeat ($urandom_range(0, 3)) @(negedge clk);
               we = 1'($urandom_range(0, 1));
               if (we) do_mem(1'b1, 32'h100 + 32'(4 * $urandom_range(0, 63)), $urandom, 1'b0, lat_a);
               else do_mem(1'b0, 32'(4 * $urandom_range(0, 127)), 32'h0, 1'b0, lat_a);
            end
         end
         begin
            repeat (30) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               do_if(32'(4 * $urandom_range(0, 63)), lat_b, sn);
            end
         end
      join

      // timeout on a load
      ack_en = 1'b0;
      fixed_lat = 0;
      do_mem(1'b0, 32'h48, 32'h0, 1'b1, lat_a);
      check("timeout_lat", 32'(lat_a), 32'd16);
      check("timeout_req_cycles", 32'(last_req_cycles), 32'd15);
      check("timeout_err_set", 32'(timeout_err), 32'd1);
      ack_en = 1'b1;
      do_if(32'h2C, lat_a, sn);
      check("timeout_err_sticky", 32'(timeout_err), 32'd1);

      // reset in the middle of a MEM access, then a stray ack
      ack_en = 1'b0;
      @(negedge clk);
      mem_req = 1'b1;
      mem_we = 1'b0;
      mem_addr = 32'h4C;
      repeat (2) @(negedge clk);
      check("pre_reset_ram_req", 32'(ram_req), 32'd1);
      reset = 1'b0;
      #1;
      check("async_rst_ctrl", 32'({ram_req, ram_we, if_valid, mem_valid, timeout_err}), 32'd0);
      check("async_rst_ram_addr", ram_addr, 32'd0);
      check("async_rst_if_rdata", if_rdata, 32'd0);
      check("async_rst_mem_rdata", mem_rdata, 32'd0);
      mem_req = 1'b0;
      model_if_rdata = '0;
      model_mem_rdata = '0;
      @(negedge clk);
      reset = 1'b1;
      inject_ack = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (if_valid || mem_valid || ram_req) seen++;
      end
      check("late_ack_ignored", 32'(seen), 32'd0);
      ack_en = 1'b1;

      check("if_queue_drained", 32'(exp_if_q.size()), 32'd0);
      check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
